// File: rtl/emu_time_sched.sv
// Emulated-time scheduler: advances global time to the earliest enabled channel edge, with run/step/halt control.
// Optional build macro EMU_TIME_HALT_ON_TRIG_EN makes any trigger hit while running halt the scheduler.
module emu_time_sched #(
    parameter int N_CH       = 4,
    parameter int TIME_WIDTH = 32,
    parameter int N_TRIG     = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH*TIME_WIDTH-1:0]   time_in,
    input  logic [N_CH-1:0]              ch_en,
    input  logic                         run_req,
    input  logic                         step_req,
    input  logic [N_TRIG*TIME_WIDTH-1:0] trig_time,
    input  logic [N_TRIG-1:0]            trig_arm,
    output logic [TIME_WIDTH-1:0]        time_next,
    output logic [TIME_WIDTH-1:0]        time_curr,
    output logic [N_CH-1:0]              time_eq,
    output logic                         running,
    output logic [N_TRIG-1:0]            trig_flag,
    output logic                         mono_err,
    output logic [CNT_WIDTH-1:0]         adv_cnt,
    output logic [1:0]                   fsm_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [TIME_WIDTH-1:0] NEVER = '1;

`ifdef EMU_TIME_HALT_ON_TRIG_EN
    localparam logic HALT_ON_TRIG = 1'b1;
`else
    localparam logic HALT_ON_TRIG = 1'b0;
`endif

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              adv;
    logic [N_TRIG-1:0] armed;
    logic [N_TRIG-1:0] hit;

    // Disabled channels never beat NEVER, so an all-disabled set yields NEVER.
    always_comb begin
        time_next = NEVER;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_en[i] && (time_in[i*TIME_WIDTH +: TIME_WIDTH] < time_next))
                time_next = time_in[i*TIME_WIDTH +: TIME_WIDTH];
        end
    end

    assign adv = ((state == S_RUN) || step_req) && (time_next != NEVER);

    always_comb begin
        time_eq = '0;
        for (int i = 0; i < N_CH; i++)
            time_eq[i] = adv && ch_en[i] && (time_in[i*TIME_WIDTH +: TIME_WIDTH] == time_next);
    end

    // Triggers compare against the registered time, so a hit lands one cycle after the crossing advance.
    always_comb begin
        hit = '0;
        for (int k = 0; k < N_TRIG; k++)
            hit[k] = armed[k] && (time_curr >= trig_time[k*TIME_WIDTH +: TIME_WIDTH]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (run_req) state_nxt = S_RUN;
            S_RUN: begin
                if (!run_req)
                    state_nxt = S_IDLE;
                else if (HALT_ON_TRIG && (|hit))
                    state_nxt = S_HALT;
            end
            S_HALT: if (!run_req) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            time_curr <= '0;
            mono_err  <= 1'b0;
            adv_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (adv) begin
                time_curr <= time_next;
                adv_cnt   <= adv_cnt + CNT_WIDTH'(1);
                if (time_next < time_curr)
                    mono_err <= 1'b1;
            end
        end
    end

    // Arming takes priority over a same-cycle hit, leaving the flag cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed     <= '0;
            trig_flag <= '0;
        end else begin
            for (int k = 0; k < N_TRIG; k++) begin
                if (trig_arm[k]) begin
                    armed[k]     <= 1'b1;
                    trig_flag[k] <= 1'b0;
                end else if (hit[k]) begin
                    armed[k]     <= 1'b0;
                    trig_flag[k] <= 1'b1;
                end
            end
        end
    end

    assign running   = (state == S_RUN);
    assign fsm_state = state;

endmodule

// File: tb/tb_emu_time_sched.sv
// Bench for emu_time_sched: expected fire patterns are queued when stimulus is driven and popped when time_eq strobes.
// Uses a 4-bit advance counter so the wrap boundary is reachable.
module tb_emu_time_sched;

    localparam int N_CH = 4;
    localparam int TW   = 32;
    localparam int N_TRIG = 2;
    localparam int CW   = 4;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [TW-1:0] NEVER = '1;

`ifdef EMU_TIME_HALT_ON_TRIG_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic                        clk;
    logic                        rst;
    logic [N_CH-1:0][TW-1:0]     tin;
    logic [N_CH-1:0]             ch_en;
    logic                        run_req;
    logic                        step_req;
    logic [N_TRIG-1:0][TW-1:0]   trig_t;
    logic [N_TRIG-1:0]           trig_arm;
    logic [TW-1:0]               time_next;
    logic [TW-1:0]               time_curr;
    logic [N_CH-1:0]             time_eq;
    logic                        running;
    logic [N_TRIG-1:0]           trig_flag;
    logic                        mono_err;
    logic [CW-1:0]               adv_cnt;
    logic [1:0]                  fsm_state;

    logic [N_CH+TW-1:0] exp_q[$];
    logic [N_CH+TW-1:0] mon_exp;
    int n_cmp = 0;
    int n_err = 0;

    emu_time_sched #(
        .N_CH(N_CH), .TIME_WIDTH(TW), .N_TRIG(N_TRIG), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .time_in(tin), .ch_en(ch_en),
        .run_req(run_req), .step_req(step_req), .trig_time(trig_t), .trig_arm(trig_arm),
        .time_next(time_next), .time_curr(time_curr), .time_eq(time_eq), .running(running),
        .trig_flag(trig_flag), .mono_err(mono_err), .adv_cnt(adv_cnt), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fire(input logic [N_CH-1:0] eq, input logic [TW-1:0] t);
        exp_q.push_back({eq, t});
    endtask

    task automatic do_reset;
        rst      = 1'b0;
        run_req  = 1'b0;
        step_req = 1'b0;
        ch_en    = '0;
        trig_arm = '0;
        tin      = '0;
        trig_t   = '0;
        repeat (2) tick;
        rst = 1'b1;
        tick;
    endtask

    // Fire monitor samples on the falling edge, between input updates and the next active edge.
    always @(negedge clk) begin
        if (rst && (time_eq != '0)) begin
            if (exp_q.size() == 0) begin
                check("fire_unexpected", {60'd0, time_eq}, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("fire", {28'd0, time_eq, time_next}, {28'd0, mon_exp});
            end
        end
    end

    initial begin
        rst = 1'b1; run_req = 1'b0; step_req = 1'b0; ch_en = '0;
        trig_arm = '0; tin = '0; trig_t = '0;
        #1 rst = 1'b0;
        #1;
        check("rst_time_curr", time_curr, 0);
        check("rst_adv_cnt", adv_cnt, 0);
        check("rst_trig_flag", trig_flag, 0);
        check("rst_mono_err", mono_err, 0);
        check("rst_running", running, 0);
        check("rst_state", fsm_state, S_IDLE);
        tick; tick;
        rst = 1'b1;
        tick;

        // Running with no enabled channel never advances.
        run_req = 1'b1;
        tick;
        check("noch_running", running, 1);
        check("noch_state", fsm_state, S_RUN);
        check("noch_next", time_next, NEVER);
        check("noch_eq", time_eq, 0);
        tick; tick;
        check("noch_adv_cnt", adv_cnt, 0);
        check("noch_time_curr", time_curr, 0);

        // Tie on the minimum; dropping run_req in the same cycle keeps that last advance.
        tin[0] = 25; tin[1] = 10; tin[2] = 10; tin[3] = 40;
        ch_en = 4'hF;
        run_req = 1'b0;
        expect_fire(4'b0110, 10);
        #1 check("tie_next", time_next, 10);
        tick;
        check("tie_time_curr", time_curr, 10);
        check("tie_adv_cnt", adv_cnt, 1);
        check("tie_stop", fsm_state, S_IDLE);
        ch_en = '0;
        tick;

        // Single step in IDLE, then idle cycles and a step with nothing enabled.
        do_reset;
        tin[0] = 7; tin[1] = 100; tin[2] = 100; tin[3] = 100;
        ch_en = 4'b0001;
        step_req = 1'b1;
        expect_fire(4'b0001, 7);
        tick;
        step_req = 1'b0;
        check("step_time_curr", time_curr, 7);
        check("step_adv_cnt", adv_cnt, 1);
        check("step_state", fsm_state, S_IDLE);
        check("step_mono", mono_err, 0);
        tick;
        check("step_idle_hold", adv_cnt, 1);
        ch_en = '0;
        step_req = 1'b1;
        tick;
        step_req = 1'b0;
        check("step_none_cnt", adv_cnt, 1);
        check("step_none_time", time_curr, 7);

        // Trigger at 100 with channel 0 stepping by 30.
        do_reset;
        trig_t[0] = 100; trig_t[1] = NEVER;
        trig_arm = 2'b01;
        tick;
        trig_arm = '0;
        check("arm_flag0", trig_flag, 0);
        run_req = 1'b1;
        tick;
        check("trg_running", running, 1);
        for (int k = 0; k <= 5; k++) begin
            tin[0] = TW'(30 * k);
            ch_en = 4'b0001;
            expect_fire(4'b0001, TW'(30 * k));
            tick;
            check("trg_time_curr", time_curr, 30 * k);
            check("trg_flag", trig_flag, (k >= 5) ? 2'b01 : 2'b00);
            check("trg_running", running, (HALT_EN && k >= 5) ? 1'b0 : 1'b1);
        end
        tin[0] = 180;
        if (!HALT_EN) expect_fire(4'b0001, 180);
        tick;
        check("trg_after_time", time_curr, HALT_EN ? 150 : 180);
        check("trg_after_state", fsm_state, HALT_EN ? S_HALT : S_RUN);
        run_req = 1'b0;
        ch_en = '0;
        tick;
        check("trg_idle", fsm_state, S_IDLE);
        check("trg_adv_cnt", adv_cnt, HALT_EN ? 6 : 7);
        trig_arm = 2'b01;
        tick;
        trig_arm = '0;
        check("rearm_clears", trig_flag, 0);
        tick;
        check("rearm_hit", trig_flag, 2'b01);

        // Backward step sets a sticky monotonicity error.
        do_reset;
        tin[1] = 100; tin[2] = 100; tin[3] = 100;
        ch_en = 4'b0001;
        tin[0] = 50; step_req = 1'b1; expect_fire(4'b0001, 50);
        tick;
        check("mono_50", time_curr, 50);
        check("mono_clear", mono_err, 0);
        tin[0] = 20; expect_fire(4'b0001, 20);
        tick;
        check("mono_20", time_curr, 20);
        check("mono_set", mono_err, 1);
        tin[0] = 60; expect_fire(4'b0001, 60);
        tick;
        step_req = 1'b0;
        ch_en = '0;
        check("mono_60", time_curr, 60);
        check("mono_sticky", mono_err, 1);

        // Asynchronous reset in the middle of a cycle while running with a flag set.
        run_req = 1'b1;
        trig_t[1] = 0;
        trig_arm = 2'b10;
        tick;
        trig_arm = '0;
        tick;
        check("pre_rst_running", running, 1);
        check("pre_rst_flag", trig_flag, 2'b10);
        #3 rst = 1'b0;
        #1;
        check("arst_time_curr", time_curr, 0);
        check("arst_adv_cnt", adv_cnt, 0);
        check("arst_mono", mono_err, 0);
        check("arst_flag", trig_flag, 0);
        check("arst_running", running, 0);
        check("arst_state", fsm_state, S_IDLE);
        check("arst_eq", time_eq, 0);
        tick;
        do_reset;

        // Advance counter wraps at 2^CW.
        run_req = 1'b1;
        tick;
        for (int k = 0; k < 16; k++) begin
            tin[0] = TW'(k);
            ch_en = 4'b0001;
            expect_fire(4'b0001, TW'(k));
            tick;
            check("wrap_cnt", adv_cnt, (k + 1) & 15);
        end
        run_req = 1'b0;
        ch_en = '0;
        tick;
        tick;

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
